// File: rtl/alu_pkg.sv
// Shared types and defaults for the parameterised ALU.
// Holds opcode/state enums, default sizes and an opcode helper.
package alu_pkg;

  localparam int WIDTH_DEF       = 8;
  localparam int MULT_STAGES_DEF = 3;

  typedef enum logic [2:0] {
    NOP = 3'b000,
    ADD = 3'b001,
    AND = 3'b010,
    XOR = 3'b011,
    MUL = 3'b100,
    SUB = 3'b101
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    MULT = 1'b1
  } state_t;

  // Opcodes 110/111 have no operation behind them.
  function automatic logic op_illegal(
    input logic [2:0] o
  );
    return (o == 3'b110) || (o == 3'b111);
  endfunction

endpackage

// File: rtl/alu_mult_pipe.sv
// Pipelined unsigned multiplier with a valid tag per stage.
// Ports: clk, reset, in_vld/a/b in, out_vld/prod out (2*WIDTH).
module alu_mult_pipe #(
  parameter int WIDTH       = 8,
  parameter int MULT_STAGES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_vld,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_vld,
  output logic [2*WIDTH-1:0] prod
);

  // The top adds one output register, so the pipe
  // itself carries one stage fewer than the latency.
  localparam int NST = MULT_STAGES - 1;
  localparam int RW  = 2 * WIDTH;

  logic [NST-1:0] vld_q;
  logic [RW-1:0]  prod_q [NST];
  logic [RW-1:0]  a_x;
  logic [RW-1:0]  b_x;

  assign a_x = {{WIDTH{1'b0}}, a};
  assign b_x = {{WIDTH{1'b0}}, b};

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < NST; i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= in_vld;
      prod_q[0] <= a_x * b_x;
      for (int i = 1; i < NST; i++) begin
        vld_q[i]  <= vld_q[i-1];
        prod_q[i] <= prod_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[NST-1];
  assign prod    = prod_q[NST-1];

endmodule

// File: rtl/param_alu.sv
// Parameterised ALU: 1-cycle add/and/xor/sub, pipelined mul.
// Ports: clk, reset, A, B, op, start in; busy, done, err, result out.
module param_alu
  import alu_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int MULT_STAGES = MULT_STAGES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         op,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2*WIDTH-1:0] result
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(MULT_STAGES);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;

  logic            accept;
  logic            vld_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]      op_q;

  logic            is_add;
  logic            is_and;
  logic            is_xor;
  logic            is_sub;
  logic            is_mul;

  logic [RW-1:0]   a_x;
  logic [RW-1:0]   b_x;
  logic [RW-1:0]   alu_res;
  logic            alu_err;

  logic            mul_in_vld;
  logic            mul_out_vld;
  logic [RW-1:0]   mul_out;

  // busy is the registered view of the MULT state, so a
  // request in the mul done cycle sees busy=0.
  assign accept = start & ~busy & (op != NOP);

  // Capture stage: operands frozen at accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= NOP;
    end else begin
      vld_q <= accept;
      if (accept) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= op;
      end
    end
  end

  assign is_add = (op_q == ADD);
  assign is_and = (op_q == AND);
  assign is_xor = (op_q == XOR);
  assign is_sub = (op_q == SUB);
  assign is_mul = (op_q == MUL);

  assign a_x = {{WIDTH{1'b0}}, a_q};
  assign b_x = {{WIDTH{1'b0}}, b_q};

  // Subtraction at full result width gives the
  // sign-extended two's-complement difference.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    unique case (1'b1)
      is_add:  alu_res = a_x + b_x;
      is_and:  alu_res = a_x & b_x;
      is_xor:  alu_res = a_x ^ b_x;
      is_sub:  alu_res = a_x - b_x;
      is_mul:  alu_res = '0;
      default: alu_err = op_illegal(op_q);
    endcase
  end

  assign mul_in_vld = vld_q & is_mul;

  alu_mult_pipe #(
    .WIDTH       (WIDTH),
    .MULT_STAGES (MULT_STAGES)
  ) u_mult (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (mul_in_vld),
    .a       (a_q),
    .b       (b_q),
    .out_vld (mul_out_vld),
    .prod    (mul_out)
  );

  assign cnt_nxt = cnt + CW'(1);

  // Control FSM; busy covers the MULT cycles only and
  // drops one cycle before the product emerges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && (op == MUL)) begin
            state <= MULT;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        MULT: begin
          cnt <= cnt_nxt;
          if (cnt_nxt == CW'(MULT_STAGES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: mul completion and a 1-cycle op can
  // never coincide, since busy blocks that accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (mul_out_vld) begin
        done   <= 1'b1;
        result <= mul_out;
      end else if (vld_q && !is_mul) begin
        done <= 1'b1;
        err  <= alu_err;
        if (!alu_err) begin
          result <= alu_res;
        end
      end
    end
  end

endmodule
